bidi_message_queue_client: RTL and testbench
============================================

# bidi_message_queue_client

Client-side endpoint of the bidirectional message queue. Attaches to the `msg_q_client` modport of `bidi_message_queue_if` and buffers both directions. Outbound words from the queue go into an RX FIFO and are delivered to local logic with message framing decoded. Locally generated messages go through a TX FIFO onto the inbound channel, and their framing is tracked. Message format: header word (`[31:16]` tag, `[15:0]` payload length N), followed by N payload words (N may be 0).

## Interface
Parameters:
- `DEPTH`, default 8: entries in each FIFO; power of two, minimum 2.

Ports:
- `clk` input, 1 bit: single clock.
- `rst` input, 1 bit: synchronous reset, active-high.
- `mq` interface, `bidi_message_queue_if.msg_q_client`: queue side. Reads `outbound_valid`/`outbound_data` and drives `outbound_ready`. Drives `inbound_valid`/`inbound_data` and reads `inbound_ready`.
- `rx_valid` output, 1 bit: RX FIFO head word is valid.
- `rx_ready` input, 1 bit: local consumer accepts the head word.
- `rx_data` output, 32 bits: head word.
- `rx_sop` output, 1 bit: head word is a header.
- `rx_eop` output, 1 bit: head word is the last word of its message.
- `tx_valid` input, 1 bit: local producer word is valid.
- `tx_ready` output, 1 bit: TX FIFO can accept a word.
- `tx_data` input, 32 bits: producer word; the first word of each message is its header.
- `tx_last` input, 1 bit: producer marks the final word.
- `tx_done` output, 1 bit: one-cycle pulse when a complete TX message has been accepted.
- `err` output, 1 bit: sticky framing error (see Configuration).

## Operation
- **Transfer rule.** A transfer occurs on a channel when valid && ready at a rising `clk`.
- **RX path.**
  - `outbound_ready = !rx_full`, registered from the FIFO count.
  - Each accepted outbound word is pushed into the RX FIFO together with computed sop/eop tags.
- **RX framing FSM**, evaluated at push time:
  - States: RX_HDR, RX_PAY.
  - RX_HDR: the pushed word is tagged sop=1.
    - If `[15:0]`==0: eop=1 and the FSM stays in RX_HDR.
    - Otherwise: load `rx_rem` = N and go to RX_PAY.
  - RX_PAY: each push decrements `rx_rem`. When `rx_rem` is 1, tag eop=1 and return to RX_HDR.
- **TX path.**
  - `tx_ready = !tx_full`.
  - `inbound_valid = !tx_empty`, and `inbound_data` = TX FIFO head.
  - Pop on `inbound_valid && inbound_ready`.
- **TX framing FSM**, evaluated on tx transfers:
  - States: TX_HDR, TX_PAY, same structure as RX.
  - The expected-last word is the header when N==0, otherwise the Nth payload word.
  - `tx_done` pulses in the cycle after the expected-last word is accepted.
- **Counters.** `rx_rem`/`tx_rem` are 16-bit unsigned. Counters never decrement below 1 in the PAY states. N=65535 is legal.
- **FIFO pointers.** Read/write pointers are log2(DEPTH) bits, wrap naturally, and full/empty come from a separate count of log2(DEPTH)+1 bits.
- **Simultaneous push and pop.**
  - When neither full nor empty: the count is unchanged and the data order is preserved.
  - When full: the push is refused because ready is low. There is no pass-through.
  - When empty: no bypass; the word is visible one cycle later.

## Timing
- **Reset values.** `outbound_ready`=0 during `rst`. After reset it is 1 from the first cycle with `rst` low.
- **Cleared by reset.** `inbound_valid`, `inbound_data`, `rx_valid`, `rx_data`, `rx_sop`, `rx_eop`, `tx_done` and `err` are all 0.
- **FSMs and contents.** Both FSMs enter the HDR state, and both FIFOs become empty.
- **Latency.** A word accepted at edge t is visible at the FIFO output after edge t, i.e. cycle t+1, in both directions.
- **Throughput.** One word per cycle per direction; the two directions are fully independent.
- **Reset mid-message.** Partial messages are discarded, both FIFOs are flushed, and no `tx_done` pulse is emitted for the aborted message.
- **Valid stability.** Once asserted, `rx_valid` and `inbound_valid` stay high, with data stable, until the word is accepted.

## Configuration
- **`BIDI_MSG_Q_CLIENT_CHECK_EN` defined.** The TX framing checker is compiled in. `err` is set, and stays set until `rst`, when either of these occurs:
  - `tx_last`=1 on a word that is not the expected-last word.
  - `tx_last`=0 on the expected-last word.
- **Framing is count-driven either way.** The TX FSM follows the header count regardless of `tx_last`, and words are forwarded unchanged.
- **`BIDI_MSG_Q_CLIENT_CHECK_EN` undefined.** The checker is removed, `err` is tied to 0, and `tx_last` is ignored.

## Test plan
- **Reset.** Assert `rst` for 3 cycles → all outputs 0. `outbound_ready`=1 in the first cycle after release.
- **RX framing.** Outbound words 0x00AB0002, 0x11, 0x22, then 0x00CD0000, consumer always ready → rx stream as follows:
  - 0x00AB0002 with sop=1, eop=0.
  - 0x11 with sop=0, eop=0.
  - 0x22 with eop=1.
  - 0x00CD0000 with sop=1, eop=1.
- **RX backpressure.** With DEPTH=8 and `rx_ready`=0, stream 10 words → exactly 8 accepted and `outbound_ready`=0. Release `rx_ready` → all 10 words are delivered in order.
- **TX message.** Send header 0x00010003 plus 3 words with `tx_last` on the 4th, `inbound_ready`=1 → 4 words on `inbound_data` in order. `tx_done` pulses once, one cycle after the 4th acceptance. `err`=0.
- **TX framing error.** With the macro defined, header 0x00000002 and `tx_last`=1 on the first payload word → `err`=1 next cycle and held. `tx_done` still pulses after the 2nd payload word.
- **Reset mid-message.** Assert `rst` while the RX FSM is in RX_PAY with 3 words buffered → FIFOs empty. The next outbound word 0x00000000 is tagged sop=1, eop=1.

Source files
------------

// File: rtl/bidi_message_queue_client_if.sv
// Queue-side handshake bundle between the message queue and a client endpoint.
// Outbound flows queue->client, inbound flows client->queue; valid/ready on both.
interface bidi_message_queue_if;
    logic        outbound_valid;
    logic        outbound_ready;
    logic [31:0] outbound_data;
    logic        inbound_valid;
    logic        inbound_ready;
    logic [31:0] inbound_data;

    modport msg_q_client (
        input  outbound_valid,
        input  outbound_data,
        output outbound_ready,
        output inbound_valid,
        output inbound_data,
        input  inbound_ready
    );

    modport msg_q (
        output outbound_valid,
        output outbound_data,
        input  outbound_ready,
        input  inbound_valid,
        input  inbound_data,
        output inbound_ready
    );
endinterface

// File: rtl/bidi_message_queue_client.sv
// Client endpoint: RX/TX FIFOs with message framing; BIDI_MSG_Q_CLIENT_CHECK_EN adds the TX framing checker.
// Latency: a word accepted at edge t appears at the FIFO output in cycle t+1, both directions.
// Backpressure: ready drops only when the FIFO is full; no bypass, no pass-through.
module bidi_msg_q_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero while empty so the outputs read 0 after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module bidi_message_queue_client #(
    parameter int DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    bidi_message_queue_if.msg_q_client       mq,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [31:0]                      rx_data,
    output logic                             rx_sop,
    output logic                             rx_eop,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    input  logic [31:0]                      tx_data,
    input  logic                             tx_last,
    output logic                             tx_done,
    output logic                             err
);
    typedef enum logic {RX_HDR, RX_PAY} rx_state_t;
    typedef enum logic {TX_HDR, TX_PAY} tx_state_t;

    rx_state_t   rx_state;
    tx_state_t   tx_state;
    logic [15:0] rx_rem;
    logic [15:0] tx_rem;

    logic        rx_full;
    logic        rx_empty;
    logic        ob_push;
    logic        in_sop;
    logic        in_eop;

    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic        tx_exp_last;

    // ---------------- RX direction ----------------
    assign mq.outbound_ready = !rx_full && !rst;
    assign ob_push           = mq.outbound_valid && mq.outbound_ready;
    assign rx_valid          = !rx_empty;

    always_comb begin
        in_sop = (rx_state == RX_HDR);
        in_eop = 1'b0;
        if (rx_state == RX_HDR) begin
            in_eop = (mq.outbound_data[15:0] == 16'd0);
        end else begin
            in_eop = (rx_rem == 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_HDR;
            rx_rem   <= 16'd0;
        end else if (ob_push) begin
            case (rx_state)
                RX_HDR: begin
                    if (mq.outbound_data[15:0] != 16'd0) begin
                        rx_rem   <= mq.outbound_data[15:0];
                        rx_state <= RX_PAY;
                    end
                end
                RX_PAY: begin
                    if (rx_rem == 16'd1) begin
                        rx_state <= RX_HDR;
                    end else begin
                        rx_rem <= rx_rem - 16'd1;
                    end
                end
                default: rx_state <= RX_HDR;
            endcase
        end
    end

    // Framing tags travel through the FIFO alongside their word.
    bidi_msg_q_fifo #(.WIDTH(34), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ob_push),
        .din   ({in_sop, in_eop, mq.outbound_data}),
        .pop   (rx_ready),
        .dout  ({rx_sop, rx_eop, rx_data}),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- TX direction ----------------
    assign tx_ready         = !tx_full;
    assign tx_push          = tx_valid && tx_ready;
    assign mq.inbound_valid = !tx_empty;

    always_comb begin
        tx_exp_last = 1'b0;
        if (tx_state == TX_HDR) begin
            tx_exp_last = (tx_data[15:0] == 16'd0);
        end else begin
            tx_exp_last = (tx_rem == 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_HDR;
            tx_rem   <= 16'd0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= tx_push && tx_exp_last;
            if (tx_push) begin
                case (tx_state)
                    TX_HDR: begin
                        if (tx_data[15:0] != 16'd0) begin
                            tx_rem   <= tx_data[15:0];
                            tx_state <= TX_PAY;
                        end
                    end
                    TX_PAY: begin
                        if (tx_rem == 16'd1) begin
                            tx_state <= TX_HDR;
                        end else begin
                            tx_rem <= tx_rem - 16'd1;
                        end
                    end
                    default: tx_state <= TX_HDR;
                endcase
            end
        end
    end

    bidi_msg_q_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (mq.inbound_ready),
        .dout  (mq.inbound_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

`ifdef BIDI_MSG_Q_CLIENT_CHECK_EN
    // tx_last is only advisory: framing follows the header count, mismatches just flag err.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (tx_push && (tx_last != tx_exp_last)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_tx_last;
    assign unused_tx_last = tx_last;
    assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_bidi_message_queue_client.sv
// Scoreboard bench: message-level generators fill expected queues, a negedge monitor checks every transfer.
module tb_bidi_message_queue_client;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid, rx_ready, rx_sop, rx_eop;
    logic [31:0] rx_data;
    logic        tx_valid, tx_ready, tx_last, tx_done, err;
    logic [31:0] tx_data;

    always #5 clk = ~clk;

    bidi_message_queue_if mq_if ();

    bidi_message_queue_client #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .mq       (mq_if),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_sop   (rx_sop),
        .rx_eop   (rx_eop),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_done  (tx_done),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;
    int ob_gap_pct = 0, tx_gap_pct = 0, rx_rdy_pct = 100, inb_rdy_pct = 100;
    int ob_acc_cnt = 0, done_seen = 0;
    bit ob_fire = 0, tx_fire = 0, done_exp = 0, err_exp = 0;

    logic [31:0] ob_q[$];     // words still to be offered on outbound
    logic [33:0] exp_rx[$];   // {sop, eop, word} expected at the rx port
    logic [33:0] tx_q[$];     // {is_last, tx_last, word} still to be offered on tx
    logic [31:0] exp_inb[$];  // words expected on inbound

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    // Message generators: framing tags come straight from the word position in the message.
    task automatic gen_rx(input logic [15:0] tag, input int n, input bit rnd, input int limit);
        logic [31:0] w;
        for (int k = 0; k <= n && k < limit; k++) begin
            w = (k == 0) ? {tag, 16'(n)} : (rnd ? $urandom : 32'(k) * 32'h11);
            ob_q.push_back(w);
            exp_rx.push_back({(k == 0), (k == n), w});
        end
    endtask

    task automatic gen_tx(input logic [15:0] tag, input int n, input bit rnd, input int bad, input int limit);
        logic [31:0] w;
        logic        is_last, tl;
        for (int k = 0; k <= n && k < limit; k++) begin
            w       = (k == 0) ? {tag, 16'(n)} : (rnd ? $urandom : 32'(k) * 32'h11);
            is_last = (k == n);
            tl      = (k == bad) ? 1'b1 : is_last;
            tx_q.push_back({is_last, tl, w});
            exp_inb.push_back(w);
        end
    endtask

    // Drivers update just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ob_fire && ob_q.size() > 0) void'(ob_q.pop_front());
        if (tx_fire && tx_q.size() > 0) void'(tx_q.pop_front());
        if (ob_q.size() > 0 && ((mq_if.outbound_valid && !ob_fire) || $urandom_range(99) >= ob_gap_pct)) begin
            mq_if.outbound_valid = 1'b1;
            mq_if.outbound_data  = ob_q[0];
        end else begin
            mq_if.outbound_valid = 1'b0;
        end
        if (tx_q.size() > 0 && ((tx_valid && !tx_fire) || $urandom_range(99) >= tx_gap_pct)) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0][31:0];
            tx_last  = tx_q[0][32];
        end else begin
            tx_valid = 1'b0;
        end
        rx_ready            = ($urandom_range(99) < rx_rdy_pct);
        mq_if.inbound_ready = ($urandom_range(99) < inb_rdy_pct);
    end

    // Monitor: inputs are stable here, so valid && ready now means a transfer at the next edge.
    always @(negedge clk) begin
        logic [33:0] e;
        logic [31:0] ei;
        if (rst) begin
            ob_fire  = 0;
            tx_fire  = 0;
            done_exp = 0;
            err_exp  = 0;
        end else begin
            chk("tx_done", tx_done, done_exp);
            chk("err", err, err_exp);
            if (tx_done) done_seen++;
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_extra: actual word %0h, required none", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_word", {rx_sop, rx_eop, rx_data}, e);
                end
            end
            if (mq_if.inbound_valid && mq_if.inbound_ready) begin
                if (exp_inb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inbound_extra: actual word %0h, required none", mq_if.inbound_data);
                end else begin
                    ei = exp_inb.pop_front();
                    chk("inbound_word", mq_if.inbound_data, ei);
                end
            end
            ob_fire = mq_if.outbound_valid && mq_if.outbound_ready;
            if (ob_fire) ob_acc_cnt++;
            tx_fire  = tx_valid && tx_ready && (tx_q.size() > 0);
            done_exp = tx_fire && tx_q[0][33];
`ifdef BIDI_MSG_Q_CLIENT_CHECK_EN
            if (tx_fire && (tx_q[0][33] != tx_q[0][32])) err_exp = 1;
`endif
        end
    end

    task automatic wait_idle(input int budget);
        int t = 0;
        while (t < budget && (ob_q.size() + tx_q.size() + exp_rx.size() + exp_inb.size() > 0)) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (t >= budget), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_accepted(input int budget);
        int t = 0;
        while (t < budget && (ob_q.size() + tx_q.size() > 0)) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", (t >= budget), 0);
    endtask

    task automatic do_reset();
        ob_q.delete();
        tx_q.delete();
        exp_rx.delete();
        exp_inb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_outbound_ready", mq_if.outbound_ready, 0);
        chk("rst_flags", {mq_if.inbound_valid, rx_valid, rx_sop, rx_eop, tx_done, err}, 0);
        chk("rst_data", {mq_if.inbound_data, rx_data}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outbound_ready", mq_if.outbound_ready, 1);
        chk("post_rst_valids", {mq_if.inbound_valid, rx_valid}, 0);
    endtask

    initial begin
        int d0;
        mq_if.outbound_valid = 1'b0;
        mq_if.outbound_data  = '0;
        mq_if.inbound_ready  = 1'b1;
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        do_reset();

        // RX framing: two-payload message then an empty one.
        gen_rx(16'h00AB, 2, 0, 99);
        gen_rx(16'h00CD, 0, 0, 99);
        wait_idle(200);

        // RX backpressure: only DEPTH words fit while the consumer stalls.
        rx_rdy_pct = 0;
        ob_acc_cnt = 0;
        gen_rx(16'h0BB0, 9, 1, 99);
        repeat (20) @(negedge clk);
        chk("bp_accepted", ob_acc_cnt, DEPTH);
        chk("bp_outbound_ready", mq_if.outbound_ready, 0);
        rx_rdy_pct = 100;
        wait_idle(200);
        chk("bp_total", ob_acc_cnt, 10);

        // TX message with three payload words.
        d0 = done_seen;
        gen_tx(16'h0001, 3, 0, -1, 99);
        wait_idle(200);
        chk("tx_done_count", done_seen - d0, 1);
        chk("tx_err_clean", err, err_exp);

        // TX framing error: tx_last raised early on the first payload word.
        d0 = done_seen;
        gen_tx(16'h0000, 2, 0, 1, 99);
        wait_idle(200);
        repeat (5) @(negedge clk);
        chk("err_done_count", done_seen - d0, 1);
        chk("err_held", err, err_exp);

        // Reset mid-message in both directions.
        rx_rdy_pct  = 0;
        inb_rdy_pct = 0;
        gen_rx(16'h0077, 5, 1, 3);
        gen_tx(16'h0066, 3, 1, -1, 2);
        wait_accepted(100);
        repeat (2) @(negedge clk);
        chk("mid_rx_buffered", rx_valid, 1);
        do_reset();
        rx_rdy_pct  = 100;
        inb_rdy_pct = 100;
        d0 = done_seen;
        gen_rx(16'h0000, 0, 0, 99);
        gen_tx(16'h0055, 1, 1, -1, 99);
        wait_idle(200);
        chk("post_mid_done_count", done_seen - d0, 1);

        // Randomized traffic in both directions with random stalls.
        ob_gap_pct  = 30;
        tx_gap_pct  = 30;
        rx_rdy_pct  = 70;
        inb_rdy_pct = 70;
        d0 = done_seen;
        for (int i = 0; i < 30; i++) begin
            gen_rx(16'($urandom), $urandom_range(0, 6), 1, 99);
            gen_tx(16'($urandom), $urandom_range(0, 6), 1, -1, 99);
        end
        gen_rx(16'($urandom), 20, 1, 99);
        gen_tx(16'($urandom), 20, 1, -1, 99);
        wait_idle(5000);
        chk("rand_done_count", done_seen - d0, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
